// File: rtl/stim_capture_pkg.sv
// stim_capture_pkg: register indices, CTRL/STAT bit positions and FSM state type
// shared by the stim_capture input-capture peripheral.
package stim_capture_pkg;
   localparam logic [2:0] REG_PSC    = 3'd0;
   localparam logic [2:0] REG_CTRL   = 3'd1;
   localparam logic [2:0] REG_PERIOD = 3'd2;
   localparam logic [2:0] REG_WIDTH  = 3'd3;
   localparam logic [2:0] REG_STAT   = 3'd4;
   localparam int CTRL_EN    = 0;
   localparam int CTRL_POL   = 1;
   localparam int CTRL_IE    = 2;
   localparam int STAT_VALID = 0;
   localparam int STAT_OVF   = 1;
   localparam int STAT_BUSY  = 2;
   typedef enum logic [1:0] {IDLE, HIGH, LOW} cap_state_t;
endpackage

// File: rtl/stim_capture_if.sv
// stim_capture_if: Write/Addr/WData/RData peripheral bus between a master and stim_capture.
interface stim_capture_if;
   logic [3:0]  Write;
   logic [31:0] Addr;
   logic [31:0] WData;
   logic [31:0] RData;
   modport master (output Write, Addr, WData, input RData);
   modport slave (input Write, Addr, WData, output RData);
endinterface

// File: rtl/cap_sync_edge.sv
// cap_sync_edge: 2-flop synchronizer plus history flop for cap_in, polarity select,
// and single-cycle rise/fall pulses (3 clk from pin edge to the consuming FSM).
module cap_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic in_i,
   input  logic pol_i,
   output logic rise_o,
   output logic fall_o
);
   logic [1:0] sync_q;
   logic       hist_q;
   logic       cur, prev;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sync_q <= 2'b00;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], in_i};
         hist_q <= sync_q[1];
      end
   // Polarity applied to both taps so toggling POL never fakes an edge.
   assign cur    = sync_q[1] ^ pol_i;
   assign prev   = hist_q ^ pol_i;
   assign rise_o = cur & ~prev;
   assign fall_o = ~cur & prev;
endmodule

// File: rtl/stim_capture.sv
// stim_capture: memory-mapped input capture measuring period and high-time in prescaled ticks.
// Optional irq output when STIM_CAPTURE_IRQ_EN is defined.
module stim_capture
   import stim_capture_pkg::*;
#(
   parameter int MEMORY_TYPE = 0
) (
   input  logic          clk,
   input  logic          rst,
   stim_capture_if.slave bus,
   input  logic          cap_in
`ifdef STIM_CAPTURE_IRQ_EN
   ,
   output logic          irq
`endif
);
`ifdef STIM_CAPTURE_IRQ_EN
   localparam logic [2:0] CTRL_MASK = 3'b111;
`else
   localparam logic [2:0] CTRL_MASK = ~(3'b001 << CTRL_IE);
`endif
   logic [2:0]  idx;
   logic [15:0] psc_q, psc_d, psc_cnt_q, psc_cnt_d, cnt_q, cnt_d, period_q, width_q, cap_val;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        valid_q, valid_d, ovf_q, ovf_d;
   logic [31:0] rd_d, rdata_q;
   cap_state_t  state_q;
   logic        en, rise, fall, tick, busy, ovf_evt, stat_wr, unused_bits;

   assign idx         = bus.Addr[4:2];
   assign unused_bits = ^{bus.Addr[31:5], bus.Addr[1:0], bus.WData[31:16], bus.Write[3:2]};
   assign en          = ctrl_q[CTRL_EN];

   cap_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .in_i  (cap_in),
      .pol_i (ctrl_q[CTRL_POL]),
      .rise_o(rise),
      .fall_o(fall)
   );

   always_comb begin
      tick      = psc_cnt_q == psc_q;
      busy      = state_q != IDLE;
      ovf_evt   = busy && cnt_q == 16'hFFFF && tick && !rise && !fall;
      cap_val   = cnt_q + {15'd0, tick};
      stat_wr   = bus.Write[0] && idx == REG_STAT;
      psc_d     = {(bus.Write[1] && idx == REG_PSC) ? bus.WData[15:8] : psc_q[15:8],
                   (bus.Write[0] && idx == REG_PSC) ? bus.WData[7:0] : psc_q[7:0]};
      ctrl_d    = (bus.Write[0] && idx == REG_CTRL) ? bus.WData[2:0] & CTRL_MASK : ctrl_q;
      psc_cnt_d = (!en || rise || tick) ? 16'd0 : psc_cnt_q + 16'd1;
      cnt_d     = (!en || rise || !busy || ovf_evt) ? 16'd0 : cap_val;
      // A flag set in the same cycle as its W1C wins.
      valid_d   = (en && state_q == LOW && rise) || (valid_q && !(stat_wr && bus.WData[STAT_VALID]));
      ovf_d     = (en && ovf_evt) || (ovf_q && !(stat_wr && bus.WData[STAT_OVF]));
      rd_d      = idx == REG_PSC    ? {16'd0, psc_q} :
                  idx == REG_CTRL   ? {29'd0, ctrl_q} :
                  idx == REG_PERIOD ? {16'd0, period_q} :
                  idx == REG_WIDTH  ? {16'd0, width_q} :
                  idx == REG_STAT   ? {29'd0, busy, ovf_q, valid_q} : 32'd0;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         psc_q     <= '0;
         ctrl_q    <= '0;
         psc_cnt_q <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         psc_q     <= psc_d;
         ctrl_q    <= ctrl_d;
         psc_cnt_q <= psc_cnt_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         rdata_q   <= rd_d;
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q  <= IDLE;
         period_q <= '0;
         width_q  <= '0;
      end else if (!en) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (rise) state_q <= HIGH;
            HIGH:
               if (ovf_evt) state_q <= IDLE;
               else if (fall) begin
                  width_q <= cap_val;
                  state_q <= LOW;
               end
            LOW:
               if (ovf_evt) state_q <= IDLE;
               else if (rise) begin
                  period_q <= cap_val;
                  state_q  <= HIGH;
               end
            default: state_q <= IDLE;
         endcase
      end

   assign bus.RData = (MEMORY_TYPE != 0) ? rdata_q : rd_d;

`ifdef STIM_CAPTURE_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) irq_q <= 1'b0;
      else irq_q <= ctrl_q[CTRL_IE] && (valid_q || ovf_q);
   assign irq = irq_q;
`endif
endmodule

// File: tb/tb_stim_capture.sv
// tb_stim_capture: table-driven and randomized checks of stim_capture in both MEMORY_TYPE modes.
module tb_stim_capture;
   import stim_capture_pkg::*;
   typedef struct {
      int psc;
      int pol;
      int hi;
      int lo;
      int per;
      int wid;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cap_in = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   last_per, last_wid;

   stim_capture_if bus0 ();
   stim_capture_if bus1 ();
   assign bus1.Write = bus0.Write;
   assign bus1.Addr  = bus0.Addr;
   assign bus1.WData = bus0.WData;

`ifdef STIM_CAPTURE_IRQ_EN
   logic irq0, irq1;
`endif

   stim_capture #(.MEMORY_TYPE(0)) dut0 (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus0),
      .cap_in(cap_in)
`ifdef STIM_CAPTURE_IRQ_EN
      ,
      .irq   (irq0)
`endif
   );

   stim_capture #(.MEMORY_TYPE(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus1),
      .cap_in(cap_in)
`ifdef STIM_CAPTURE_IRQ_EN
      ,
      .irq   (irq1)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // All tasks start and end at a falling clock edge.
   task automatic wr(input logic [2:0] i, input logic [31:0] d);
      bus0.Write = 4'hF;
      bus0.Addr  = {27'd0, i, 2'd0};
      bus0.WData = d;
      @(negedge clk);
      bus0.Write = 4'h0;
   endtask

   task automatic rd(input string name, input logic [2:0] i, input logic [31:0] exp);
      bus0.Addr = {27'd0, i, 2'd0};
      #1 chk({name, " comb"}, bus0.RData, exp);
      @(negedge clk);
      chk({name, " reg"}, bus1.RData, exp);
   endtask

   task automatic hold(input logic v, input int n);
      cap_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic run_meas(input int psc, input int pol, input int hi, input int lo);
      wr(REG_CTRL, 32'd0);
      wr(REG_PSC, 32'(psc));
      hold(1'b0, 5);
      wr(REG_CTRL, 32'(pol * 2 + 1));
      repeat (4) begin
         hold(1'b1, hi);
         hold(1'b0, lo);
      end
      hold(1'b1, 6);
   endtask

   initial begin
      vec_t tbl[6];
      int   psc, pol, hi, lo;
      tbl = '{'{0, 0, 3, 7, 10, 3}, '{3, 0, 12, 28, 10, 3}, '{1, 0, 12, 28, 20, 6},
              '{0, 1, 7, 3, 10, 3}, '{2, 0, 5, 10, 5, 1}, '{0, 1, 1, 4, 5, 4}};
      bus0.Write = 4'h0;
      bus0.Addr  = 32'd0;
      bus0.WData = 32'd0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) rd($sformatf("reset reg%0d", i), 3'(i), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_meas(tbl[i].psc, tbl[i].pol, tbl[i].hi, tbl[i].lo);
         rd($sformatf("tbl%0d period", i), REG_PERIOD, 32'(tbl[i].per));
         rd($sformatf("tbl%0d width", i), REG_WIDTH, 32'(tbl[i].wid));
         rd($sformatf("tbl%0d stat", i), REG_STAT, 32'h5);
      end

      // Model: ticks fall on every (PSC+1)th clk after a rise, edge tick included.
      for (int t = 0; t < 12; t++) begin
         psc = $urandom_range(0, 3);
         pol = $urandom_range(0, 1);
         hi  = $urandom_range(2, 25);
         lo  = $urandom_range(2, 25);
         run_meas(psc, pol, hi, lo);
         last_per = (hi + lo) / (psc + 1);
         last_wid = (pol != 0 ? lo : hi) / (psc + 1);
         rd($sformatf("rnd%0d period", t), REG_PERIOD, 32'(last_per));
         rd($sformatf("rnd%0d width", t), REG_WIDTH, 32'(last_wid));
      end

      wr(REG_CTRL, 32'd2);
      @(negedge clk);
      rd("en off stat", REG_STAT, 32'h1);
      rd("en off period", REG_PERIOD, 32'(last_per));
      rd("en off width", REG_WIDTH, 32'(last_wid));
      rd("en off ctrl", REG_CTRL, 32'h2);

      wr(REG_STAT, 32'h3);
      rd("stat cleared", REG_STAT, 32'h0);
      wr(REG_PSC, 32'd0);
      hold(1'b0, 5);
      wr(REG_CTRL, 32'd1);
      hold(1'b1, 66000);
      rd("ovf stat", REG_STAT, 32'h2);
      rd("ovf period", REG_PERIOD, 32'(last_per));
      rd("ovf width", REG_WIDTH, 32'(last_wid));

      wr(REG_STAT, 32'h3);
      hold(1'b0, 5);
      hold(1'b1, 3);
      hold(1'b0, 7);
      hold(1'b1, 3);
      hold(1'b0, 7);
      cap_in = 1'b1;
      repeat (2) @(negedge clk);
      bus0.Write = 4'h1;
      bus0.Addr  = {27'd0, REG_STAT, 2'd0};
      bus0.WData = 32'h1;
      @(negedge clk);
      bus0.Write = 4'h0;
      rd("set wins stat", REG_STAT, 32'h5);
      rd("set wins period", REG_PERIOD, 32'd10);
      wr(REG_STAT, 32'h3);
      rd("w1c stat", REG_STAT, 32'h4);
      wr(REG_PSC, 32'h1234);
      rd("latency first", REG_STAT, 32'h4);
      bus0.Addr = {27'd0, REG_PSC, 2'd0};
      #1 chk("latency old", bus1.RData, 32'h4);
      chk("latency comb", bus0.RData, 32'h1234);
      @(negedge clk);
      chk("latency new", bus1.RData, 32'h1234);

`ifdef STIM_CAPTURE_IRQ_EN
      wr(REG_PSC, 32'd0);
      wr(REG_CTRL, 32'd0);
      wr(REG_STAT, 32'h3);
      hold(1'b0, 5);
      wr(REG_CTRL, 32'd5);
      hold(1'b1, 3);
      hold(1'b0, 7);
      cap_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("irq before", {31'd0, irq0}, 32'd0);
      @(negedge clk);
      chk("irq set", {31'd0, irq0}, 32'd1);
      chk("irq set reg", {31'd0, irq1}, 32'd1);
      wr(REG_STAT, 32'h3);
      chk("irq hold", {31'd0, irq0}, 32'd1);
      @(negedge clk);
      chk("irq clear", {31'd0, irq0}, 32'd0);
`endif

      wr(REG_PSC, 32'd5);
      wr(REG_CTRL, 32'd0);
      hold(1'b0, 5);
      wr(REG_CTRL, 32'd1);
      bus0.Addr = {27'd0, REG_PSC, 2'd0};
      hold(1'b1, 6);
      chk("pre reset psc", bus0.RData, 32'd5);
      #2 rst = 1'b0;
      #1 chk("async reset comb", bus0.RData, 32'd0);
      chk("async reset reg", bus1.RData, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) rd($sformatf("in reset reg%0d", i), 3'(i), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      run_meas(0, 0, 3, 7);
      rd("after reset period", REG_PERIOD, 32'd10);
      rd("after reset width", REG_WIDTH, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
